// File: rtl/watch_time_if.sv
// Time load/readout bundle shared by the setting block (master) and the
// timekeeping core (slave).
interface watch_time_if;
    logic        en_time;
    logic [47:0] bin_time;
    logic [7:0]  year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  second;
    logic        sec_pulse;
    logic        load_err;

    modport master (
        output en_time, bin_time,
        input  year, month, day, hour, minute, second, sec_pulse, load_err
    );

    modport slave (
        input  en_time, bin_time,
        output year, month, day, hour, minute, second, sec_pulse, load_err
    );
endinterface

// File: rtl/watch_time.sv
// Calendar timekeeping core: second..year counter advanced by a prescaled
// tick, with validated parallel load from the setting block.
module watch_time #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic          clk,
    input  logic          rst,
    watch_time_if.slave   bus
);
    localparam int unsigned PW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic [7:0]    year, month, day, hour, minute, second;
    logic          sec_pulse, load_err;

    logic          tick;
    logic          c_sec, c_min, c_hour, c_day, c_month;
    logic [7:0]    sec_n, min_n, hour_n, day_n, month_n, year_n;
    logic [7:0]    ld_year, ld_month, ld_day, ld_hour, ld_min, ld_sec;
    logic          ld_valid;

    function automatic logic [7:0] mdays(input logic [7:0] m, input logic [7:0] y);
        logic [7:0] r;
        case (m)
            8'd2:                      r = (y[1:0] == 2'd0) ? 8'd29 : 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11:   r = 8'd30;
            default:                   r = 8'd31;
        endcase
        return r;
    endfunction

    // Load image decode and range validation.
    always_comb begin
        ld_sec   = bus.bin_time[7:0];
        ld_min   = bus.bin_time[15:8];
        ld_hour  = bus.bin_time[23:16];
        ld_day   = bus.bin_time[31:24];
        ld_month = bus.bin_time[39:32];
        ld_year  = bus.bin_time[47:40];
        ld_valid = (ld_year <= 8'd99)
                && (ld_month >= 8'd1) && (ld_month <= 8'd12)
                && (ld_day >= 8'd1) && (ld_day <= mdays(ld_month, ld_year))
                && (ld_hour <= 8'd23) && (ld_min <= 8'd59) && (ld_sec <= 8'd59);
    end

    // Single-cycle carry cascade, second through year.
    always_comb begin
        tick    = (presc == P_LAST);
        c_sec   = (second == 8'd59);
        c_min   = c_sec && (minute == 8'd59);
        c_hour  = c_min && (hour == 8'd23);
        c_day   = c_hour && (day == mdays(month, year));
        c_month = c_day && (month == 8'd12);

        sec_n   = c_sec ? 8'd0 : second + 8'd1;
        min_n   = c_sec ? ((minute == 8'd59) ? 8'd0 : minute + 8'd1) : minute;
        hour_n  = c_min ? ((hour == 8'd23) ? 8'd0 : hour + 8'd1) : hour;
        day_n   = c_hour ? (c_day ? 8'd1 : day + 8'd1) : day;
        month_n = c_day ? (c_month ? 8'd1 : month + 8'd1) : month;
        year_n  = c_month ? ((year == 8'd99) ? 8'd0 : year + 8'd1) : year;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            year      <= 8'd0;
            month     <= 8'd1;
            day       <= 8'd1;
            hour      <= 8'd0;
            minute    <= 8'd0;
            second    <= 8'd0;
            sec_pulse <= 1'b0;
            load_err  <= 1'b0;
        end else if (bus.en_time) begin
            // Loads freeze the prescaler and swallow any coincident tick.
            presc     <= '0;
            sec_pulse <= 1'b0;
            load_err  <= ~ld_valid;
            if (ld_valid) begin
                year   <= ld_year;
                month  <= ld_month;
                day    <= ld_day;
                hour   <= ld_hour;
                minute <= ld_min;
                second <= ld_sec;
            end
        end else begin
            load_err  <= 1'b0;
            sec_pulse <= tick;
            if (tick) begin
                presc  <= '0;
                year   <= year_n;
                month  <= month_n;
                day    <= day_n;
                hour   <= hour_n;
                minute <= min_n;
                second <= sec_n;
            end else begin
                presc  <= presc + PW'(1);
            end
        end
    end

    assign bus.year      = year;
    assign bus.month     = month;
    assign bus.day       = day;
    assign bus.hour      = hour;
    assign bus.minute    = minute;
    assign bus.second    = second;
    assign bus.sec_pulse = sec_pulse;
    assign bus.load_err  = load_err;
endmodule

// File: tb/tb_watch_time.sv
// Bench for watch_time: model keeps time as seconds since 2000-01-01 and
// converts to calendar fields arithmetically; every cycle is compared.
module tb_watch_time;
    localparam int unsigned TD = 4;
    localparam longint CENTURY = 64'd36525 * 64'd86400;

    logic clk = 1'b0;
    logic rst;
    watch_time_if wif();

    always #5 clk = ~clk;

    watch_time #(.TICK_DIV(TD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (wif)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    longint m_t;
    int     m_cnt;
    bit     m_pulse;
    bit     m_err;

    function automatic int ylen(input int y);
        return (y % 4 == 0) ? 366 : 365;
    endfunction

    function automatic int mlen(input int m, input int y);
        int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && y % 4 == 0) return 29;
        return tbl[m-1];
    endfunction

    function automatic logic [47:0] mk(input int y, input int m, input int d,
                                       input int h, input int mi, input int s);
        return {8'(y), 8'(m), 8'(d), 8'(h), 8'(mi), 8'(s)};
    endfunction

    function automatic longint to_epoch(input logic [47:0] b);
        int y, m;
        longint days;
        y = int'(b[47:40]);
        m = int'(b[39:32]);
        days = 0;
        for (int yy = 0; yy < y; yy++) days += ylen(yy);
        for (int mm = 1; mm < m; mm++) days += mlen(mm, y);
        days += longint'(b[31:24]) - 1;
        return days * 86400 + longint'(b[23:16]) * 3600
             + longint'(b[15:8]) * 60 + longint'(b[7:0]);
    endfunction

    function automatic logic [47:0] from_epoch(input longint t);
        longint days, rem;
        int y, m;
        days = t / 86400;
        rem  = t % 86400;
        y = 0;
        while (days >= ylen(y)) begin days -= ylen(y); y++; end
        m = 1;
        while (days >= mlen(m, y)) begin days -= mlen(m, y); m++; end
        return mk(y, m, int'(days) + 1, int'(rem / 3600), int'((rem % 3600) / 60), int'(rem % 60));
    endfunction

    // Valid iff fields in range and the image survives an epoch round trip.
    function automatic bit img_ok(input logic [47:0] b);
        if (b[47:40] > 8'd99 || b[39:32] < 8'd1 || b[39:32] > 8'd12) return 1'b0;
        if (b[31:24] < 8'd1 || b[31:24] > 8'd31) return 1'b0;
        if (b[23:16] > 8'd23 || b[15:8] > 8'd59 || b[7:0] > 8'd59) return 1'b0;
        return from_epoch(to_epoch(b)) == b;
    endfunction

    task automatic model_step(input bit r, input bit e, input logic [47:0] b);
        if (r) begin
            m_t = 0; m_cnt = 0; m_pulse = 0; m_err = 0;
        end else if (e) begin
            m_cnt = 0; m_pulse = 0;
            m_err = !img_ok(b);
            if (!m_err) m_t = to_epoch(b);
        end else if (m_cnt == int'(TD) - 1) begin
            m_cnt = 0; m_pulse = 1; m_err = 0;
            m_t = (m_t + 1) % CENTURY;
        end else begin
            m_cnt++; m_pulse = 0; m_err = 0;
        end
    endtask

    task automatic compare();
        logic [49:0] exp, act;
        exp = {from_epoch(m_t), m_pulse, m_err};
        act = {wif.year, wif.month, wif.day, wif.hour, wif.minute, wif.second,
               wif.sec_pulse, wif.load_err};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL model cycle %0d: got %0d-%0d-%0d %0d:%0d:%0d p=%0b e=%0b want %0d-%0d-%0d %0d:%0d:%0d p=%0b e=%0b",
                     cyc, act[49:42], act[41:34], act[33:26], act[25:18], act[17:10], act[9:2], act[1], act[0],
                     exp[49:42], exp[41:34], exp[33:26], exp[25:18], exp[17:10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic lit(input string name, input logic [47:0] got, input logic [47:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic cycle(input bit r, input bit e, input logic [47:0] b);
        rst = r;
        wif.en_time = e;
        wif.bin_time = b;
        model_step(r, e, b);
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 48'h0);
    endtask

    function automatic logic [47:0] now();
        return {wif.year, wif.month, wif.day, wif.hour, wif.minute, wif.second};
    endfunction

    function automatic logic [47:0] rand_img();
        return mk($urandom_range(0, 103), $urandom_range(0, 13), $urandom_range(0, 32),
                  $urandom_range(20, 24), $urandom_range(57, 60), $urandom_range(56, 60));
    endfunction

    initial begin
        // Model pins: leap day, non-leap February, and century wrap.
        lit("pin_leap", from_epoch(to_epoch(mk(24, 2, 28, 23, 59, 59)) + 1), mk(24, 2, 29, 0, 0, 0));
        lit("pin_noleap", from_epoch(to_epoch(mk(23, 2, 28, 23, 59, 59)) + 1), mk(23, 3, 1, 0, 0, 0));
        lit("pin_century", 48'(to_epoch(mk(99, 12, 31, 23, 59, 59)) + 1), 48'(CENTURY));

        // Reset and count.
        cycle(1'b1, 1'b0, 48'h0);
        cycle(1'b1, 1'b0, 48'h0);
        lit("reset_fields", now(), mk(0, 1, 1, 0, 0, 0));
        idle(3);
        lit("pre_tick_sec", now(), mk(0, 1, 1, 0, 0, 0));
        idle(1);
        lit("first_tick", {now(), 7'd0, wif.sec_pulse}, {mk(0, 1, 1, 0, 0, 1), 8'd1});
        idle(4);
        lit("second_tick", {now(), 7'd0, wif.sec_pulse}, {mk(0, 1, 1, 0, 0, 2), 8'd1});

        // Minute and hour carry.
        cycle(1'b0, 1'b1, mk(0, 1, 1, 0, 59, 58));
        idle(4);
        lit("carry_59", now(), mk(0, 1, 1, 0, 59, 59));
        idle(4);
        lit("carry_hour", now(), mk(0, 1, 1, 1, 0, 0));

        // Month and leap rules.
        cycle(1'b0, 1'b1, mk(24, 2, 28, 23, 59, 59)); idle(4);
        lit("leap_feb29", now(), mk(24, 2, 29, 0, 0, 0));
        cycle(1'b0, 1'b1, mk(23, 2, 28, 23, 59, 59)); idle(4);
        lit("noleap_mar1", now(), mk(23, 3, 1, 0, 0, 0));
        cycle(1'b0, 1'b1, mk(23, 4, 30, 23, 59, 59)); idle(4);
        lit("apr30_may1", now(), mk(23, 5, 1, 0, 0, 0));

        // Full rollover.
        cycle(1'b0, 1'b1, mk(99, 12, 31, 23, 59, 59)); idle(4);
        lit("rollover", now(), mk(0, 1, 1, 0, 0, 0));

        // Invalid loads leave fields alone and restart the prescaler.
        idle(2);
        cycle(1'b0, 1'b1, mk(23, 13, 1, 0, 0, 0));
        lit("bad_month", {now(), 7'd0, wif.load_err}, {mk(0, 1, 1, 0, 0, 0), 8'd1});
        cycle(1'b0, 1'b1, mk(23, 2, 29, 0, 0, 0));
        lit("bad_feb29", {now(), 7'd0, wif.load_err}, {mk(0, 1, 1, 0, 0, 0), 8'd1});
        cycle(1'b0, 1'b1, mk(23, 1, 1, 24, 0, 0));
        lit("bad_hour", {now(), 7'd0, wif.load_err}, {mk(0, 1, 1, 0, 0, 0), 8'd1});
        idle(3);
        lit("bad_restart", now(), mk(0, 1, 1, 0, 0, 0));
        idle(1);
        lit("bad_then_tick", {now(), 7'd0, wif.load_err}, {mk(0, 1, 1, 0, 0, 1), 8'd0});

        // Held load, first cycle coinciding with a due tick.
        idle(3);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, mk(12, 6, 15, 10, 20, 30));
            lit("held_image", {now(), 7'd0, wif.sec_pulse}, {mk(12, 6, 15, 10, 20, 30), 8'd0});
        end
        idle(3);
        lit("held_wait", now(), mk(12, 6, 15, 10, 20, 30));
        idle(1);
        lit("held_release", {now(), 7'd0, wif.sec_pulse}, {mk(12, 6, 15, 10, 20, 31), 8'd1});

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0)      cycle(1'b1, 1'b0, rand_img());
            else if ($urandom_range(0, 11) == 0)  cycle(1'b0, 1'b1, rand_img());
            else                                  cycle(1'b0, 1'b0, rand_img());
        end

        // Reset wins over a simultaneous load.
        cycle(1'b1, 1'b1, mk(50, 5, 5, 5, 5, 5));
        lit("rst_over_load", {now(), 6'd0, wif.sec_pulse, wif.load_err}, {mk(0, 1, 1, 0, 0, 0), 8'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
